// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write link: frame geometry,
// peripheral register map, controller state encoding and frame packing.
package spi_pkg;

  // Frame geometry and command bit meaning
  localparam int         SPI_FRAME_BITS = 16;
  localparam logic       SPI_RW_WRITE   = 1'b1;

  // Register map of the SPI PWM peripheral
  localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

  // Pack a request into the on-wire frame, command bit first
  function automatic logic [SPI_FRAME_BITS-1:0] spi_build_frame(
    input logic       rw,
    input logic [6:0] addr,
    input logic [7:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer: while enabled, emits a one-cycle tick on the last clk
// cycle of every CLK_DIV-cycle window; disabling it clears the count so the
// next enable starts a fresh window.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count and tick: wrap on the last cycle of a window, clear when idle
  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller_tx.sv
// SPI mode-0 transmit controller: accepts {rw, addr, wdata} on start&&ready,
// shifts the 16-bit frame out MSB first, holds nCS for one half-period after
// the last falling edge, keeps nCS high for one more half-period, then pulses
// done and returns to idle. All pin-facing outputs come straight from flops.
module spi_controller_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = SPI_FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  spi_state_e            state_q,   state_d;
  logic [FRAME_BITS-1:0] shreg_q,   shreg_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  phase_q,   phase_d;
  logic                  ready_q,   ready_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  sclk_q,    sclk_d;
  logic                  ncs_q,     ncs_d;
  logic                  copi_q,    copi_d;

  logic [FRAME_BITS-1:0] frame_s;
  logic                  timer_en_s;
  logic                  tick_s;

  assign frame_s    = spi_build_frame(rw, addr, wdata);
  assign timer_en_s = (state_q != ST_IDLE);

  spi_half_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (timer_en_s),
    .tick (tick_s)
  );

  // Next-state and next-output logic; every half-period boundary is a tick
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    copi_d    = copi_q;

    case (state_q)
      ST_IDLE: begin
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        sclk_d    = 1'b0;
        ncs_d     = 1'b1;
        copi_d    = 1'b0;
        bit_cnt_d = 4'd0;
        phase_d   = 1'b0;
        if (start && ready_q) begin
          // MSB goes out with the nCS assertion; shreg keeps the rest, left-aligned
          copi_d  = frame_s[FRAME_BITS-1];
          shreg_d = {frame_s[FRAME_BITS-2:0], 1'b0};
          ncs_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (tick_s) begin
          if (!phase_q) begin
            // End of low half: rising edge, receiver samples copi here
            sclk_d  = 1'b1;
            phase_d = 1'b1;
          end else begin
            // End of high half: falling edge, advance or finish the frame
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              copi_d  = 1'b0;
              shreg_d = '0;
              state_d = ST_HOLD;
            end else begin
              copi_d    = shreg_q[FRAME_BITS-1];
              shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_HOLD: begin
        if (tick_s) begin
          ncs_d   = 1'b1;
          state_d = ST_GAP;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_GAP: begin
        if (tick_s) begin
          done_d    = 1'b1;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = 4'd0;
        phase_d   = 1'b0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        sclk_d    = 1'b0;
        ncs_d     = 1'b1;
        copi_d    = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset releases the bus at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= 4'd0;
      phase_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign ncs   = ncs_q;
  assign copi  = copi_q;

endmodule
